radix4_booth_multiplier: RTL and testbench
==========================================

// Module: radix4_booth_multiplier
// PURPOSE
//   Sequential signed radix-4 (modified Booth) multiplier, directly downstream of the LFSR
//   pair generator. Takes one signed WIDTH-bit operand pair (x, y) per start pulse.
//   Retires 2 multiplier bits per cycle and returns a signed 2*WIDTH-bit product with a
//   one-cycle done strobe. The test harness compares the result against x*y.
// PARAMETERS
//   WIDTH   8   operand width in bits; must be even and >= 4; product is 2*WIDTH bits
// PORTS
//   clk                    in   1          single clock; all state updates on rising edge
//   reset_to_multiplier_n  in   1          asynchronous, active-low reset
//   start                  in   1          request; sampled only in IDLE
//   x                      in   WIDTH      multiplicand, two's complement; captured on accept
//   y                      in   WIDTH      multiplier, two's complement; captured on accept
//   busy                   out  1          1 while in CALC or DONE
//   done                   out  1          1 for exactly one cycle when product is updated
//   product                out  2*WIDTH    signed x*y; held until the next done
// BEHAVIOUR
//   Reset (reset_to_multiplier_n=0, asynchronous):
//     - state=IDLE; busy=0, done=0, product=0
//     - all internal registers (M, Q, acc, step counter) cleared
//     - takes effect immediately, including mid-CALC; the operation in flight is discarded
//   FSM states: IDLE -> CALC -> DONE -> IDLE
//   IDLE:
//     - start=1 at an edge captures x into M (sign-extended to 2*WIDTH)
//     - captures y into Q = {y, 1'b0} (WIDTH+1 bits)
//     - clears acc (2*WIDTH) and step (0); next state CALC
//     - start=0: remain in IDLE
//   CALC (one edge per step i = 0..WIDTH/2-1):
//     - decode Q[2:0]:
//         000,111 -> 0
//         001,010 -> +M
//         011     -> +2M
//         100     -> -2M
//         101,110 -> -M
//     - acc <= acc + (pp << 2i); all arithmetic modulo 2^(2*WIDTH)
//     - Q <= Q arithmetic-shifted right by 2
//     - step increments
//     - on the last step, the final sum is written to product, done=1, next state DONE
//   DONE:
//     - done=1, busy=1 for this single cycle
//     - next edge: done=0, state IDLE
//   Latency:
//     - start accepted at edge E0; product valid and done=1 after edge E0+WIDTH/2
//       (E4 for WIDTH=8)
//     - next start can be accepted at E0+WIDTH/2+2 (6 cycles per op for WIDTH=8)
//   Handshake / boundaries:
//     - start is ignored in CALC and DONE; no queuing; captured operands stay stable
//       even if x/y change
//     - start held high continuously gives back-to-back ops, each re-sampling x/y in IDLE
//     - x=y=-2^(WIDTH-1) gives +2^(2*WIDTH-2): no overflow; -2M on the most negative M
//       is correct modulo 2^(2*WIDTH)
//     - a zero operand still takes the full WIDTH/2 steps (no early exit)
//     - product changes only on the done edge or on reset
// TESTING
//   1. Assert reset_to_multiplier_n=0 mid-idle
//        -> product=0x0000, busy=0, done=0 immediately, without waiting for clk.
//   2. x=7, y=-3 (0xFD), start pulse
//        -> done=1 exactly 4 edges after accept; product=0xFFEB (-21); done drops next cycle.
//   3. Corner cases, each run separately:
//        - x=-128, y=-128 -> 0x4000
//        - x=-128, y=127  -> 0xC080
//        - x=127,  y=127  -> 0x3F01
//        - x=0,    y=-1   -> 0x0000
//   4. start for x=5, y=6; re-pulse start with x=9, y=9 during CALC
//        -> single done with product=30; second request ignored.
//   5. Drop reset_to_multiplier_n at step 2 of an op
//        -> outputs clear at once, no done pulse.
//      Then release reset and run x=-2, y=3 -> 0xFFFA.
//   6. Chain with the LFSR generator (seed 0x8000) over 32 pairs, start held high
//        -> every product equals $signed(x)*$signed(y) of the captured pair;
//           first pair x=-128, y=0 -> 0x0000.

Source files
------------

// File: rtl/radix4_booth_multiplier.sv
// Sequential signed radix-4 (modified Booth) multiplier: one operand pair per start,
// two multiplier bits retired per cycle, one-cycle done strobe with the 2*WIDTH product.
module radix4_booth_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset_to_multiplier_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW    = 2 * WIDTH;
   localparam int STEPS = WIDTH / 2;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [PW-1:0]   r_m, r_acc, r_product;
   logic [WIDTH:0]  r_q;
   logic [SW-1:0]   r_step;
   logic [PW-1:0]   w_pp, w_sum;
   logic            w_last;

   // Booth digit from the overlapping triplet; -2M of the most negative M wraps correctly
   always_comb begin
      case (r_q[2:0])
         3'b001, 3'b010: w_pp = r_m;
         3'b011:         w_pp = r_m << 1;
         3'b100:         w_pp = -(r_m << 1);
         3'b101, 3'b110: w_pp = -r_m;
         default:        w_pp = '0;
      endcase
   end

   assign w_sum  = r_acc + (w_pp << {r_step, 1'b0});
   assign w_last = (r_step == SW'(STEPS - 1));

   always_ff @(posedge clk or negedge reset_to_multiplier_n) begin
      if (!reset_to_multiplier_n) r_state <= S_IDLE;
      else                        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CALC;
         S_CALC:  if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_to_multiplier_n) begin
      if (!reset_to_multiplier_n) begin
         r_m       <= '0;
         r_q       <= '0;
         r_acc     <= '0;
         r_step    <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_m    <= {{WIDTH{x[WIDTH-1]}}, x};
               r_q    <= {y, 1'b0};
               r_acc  <= '0;
               r_step <= '0;
            end
            S_CALC: begin
               r_acc  <= w_sum;
               r_q    <= {{2{r_q[WIDTH]}}, r_q[WIDTH:2]};
               r_step <= r_step + 1'b1;
               if (w_last) r_product <= w_sum;
            end
            default: ;
         endcase
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Directed bench for radix4_booth_multiplier (WIDTH=8): latency, corners, ignored
// restarts, async reset mid-op, and a back-to-back LFSR-fed run.
module tb_radix4_booth_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  x, y;
   logic        busy, done;
   logic [15:0] product;

   int checks = 0;
   int failures = 0;

   radix4_booth_multiplier #(.WIDTH(8)) dut (
      .clk                  (clk),
      .reset_to_multiplier_n(rst_n),
      .start                (start),
      .x                    (x),
      .y                    (y),
      .busy                 (busy),
      .done                 (done),
      .product              (product)
   );

   always #5 clk = ~clk;

   // Pulse start for one accept edge, then count edges until done (bounded).
   task automatic do_op(input logic [7:0] xv, input logic [7:0] yv,
                        output int lat, output logic [15:0] p);
      @(negedge clk);
      x = xv; y = yv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 20);
      p = product;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int lat; logic [15:0] p;
      rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
      #12;
      checks++;
      if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_init: product=%h busy=%b done=%b, want 0000/0/0", product, busy, done);
      end
      @(negedge clk); rst_n = 1'b1;
      do_op(8'd7, 8'hFD, lat, p);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_async_idle: product=%h busy=%b done=%b, want 0000/0/0", product, busy, done);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      @(negedge clk);
      x = 8'd7; y = 8'hFD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x = 8'h55; y = 8'h55;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy: busy=%b, want 1", busy);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 20);
      checks++;
      if (lat != 4) begin
         failures++;
         $display("FAIL basic_latency: edges=%0d, want 4", lat);
      end
      checks++;
      if (product !== 16'hFFEB) begin
         failures++;
         $display("FAIL basic_product: product=%h, want ffeb", product);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 16'hFFEB) begin
         failures++;
         $display("FAIL basic_after: done=%b busy=%b product=%h, want 0/0/ffeb", done, busy, product);
      end
   endtask

   task automatic test_corners();
      logic [7:0]  cx [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
      logic [7:0]  cy [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
      logic [15:0] ce [4] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};
      int lat; logic [15:0] p;
      for (int i = 0; i < 4; i++) begin
         do_op(cx[i], cy[i], lat, p);
         checks++;
         if (p !== ce[i] || lat != 4) begin
            failures++;
            $display("FAIL corner_%0d: product=%h lat=%0d, want %h lat=4", i, p, lat, ce[i]);
         end
      end
   endtask

   task automatic test_restart_ignored();
      int ndone = 0;
      logic [15:0] p = 'x;
      @(negedge clk);
      x = 8'd5; y = 8'd6; start = 1'b1;
      @(negedge clk);
      x = 8'd9; y = 8'd9;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 2) start = 1'b0;
         if (done) begin ndone++; p = product; end
      end
      checks++;
      if (ndone != 1) begin
         failures++;
         $display("FAIL restart_done_count: dones=%0d, want 1", ndone);
      end
      checks++;
      if (p !== 16'd30) begin
         failures++;
         $display("FAIL restart_product: product=%h, want 001e", p);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat, ndone = 0; logic [15:0] p;
      @(negedge clk);
      x = 8'd11; y = 8'd13; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_calc: product=%h busy=%b done=%b, want 0000/0/0", product, busy, done);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (done) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         failures++;
         $display("FAIL reset_no_done: dones=%0d, want 0", ndone);
      end
      do_op(8'hFE, 8'd3, lat, p);
      checks++;
      if (p !== 16'hFFFA || lat != 4) begin
         failures++;
         $display("FAIL after_reset_op: product=%h lat=%0d, want fffa lat=4", p, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] lfsr = 16'h8000;
      logic signed [7:0]  sx, sy;
      logic signed [15:0] e;
      int cyc;
      @(negedge clk);
      for (int n = 0; n < 32; n++) begin
         x = lfsr[15:8]; y = lfsr[7:0]; start = 1'b1;
         sx = lfsr[15:8]; sy = lfsr[7:0];
         e = sx * sy;
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!done && cyc < 20);
         checks++;
         if (!done || product !== e) begin
            failures++;
            $display("FAIL b2b_%0d: x=%h y=%h product=%h done=%b, want %h", n, sx, sy, product, done, e);
         end
         if (n == 0) begin
            checks++;
            if (product !== 16'h0000) begin
               failures++;
               $display("FAIL b2b_first: product=%h, want 0000", product);
            end
         end
         lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_restart_ignored();
      test_reset_mid_calc();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
